// File: rtl/tile_store_controller.sv
// Store-side tile controller: drains result rows to memory one write at a time.
// Optional ack watchdog enabled by defining STORE_TIMEOUT_EN.
module tile_store_controller #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned SIZE_W         = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [SIZE_W-1:0] msize,
    input  logic [SIZE_W-1:0] nsize,
    input  logic              can_store,
    input  logic              res_valid,
    input  logic              interface_ack,
    output logic              store,
    output logic              busy,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic              interface_rdwr_store,
    output logic [SIZE_W-1:0] interface_control_store,
    output logic              res_buff_read,
    output logic              done_store,
    output logic              err_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [SIZE_W-1:0] r_msize;
    logic [SIZE_W-1:0] r_nsize;
    logic [SIZE_W-1:0] r_row_cnt;

    logic              w_last;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_timeout;

    // One extra bit so a full-scale msize never wraps the last-row compare.
    assign w_last      = ({1'b0, r_row_cnt} + (SIZE_W+1)'(1)) == {1'b0, r_msize};
    assign w_next_addr = r_addr + r_stride;

`ifdef STORE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout   = (r_state == S_WAIT) && !interface_ack &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err;

    // Held at zero outside WAIT_ACK so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_to_cnt <= '0;
            end else if (!interface_ack) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_stride  <= '0;
            r_msize   <= '0;
            r_nsize   <= '0;
            r_row_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_store) begin
                        r_addr    <= tile_C_addr;
                        r_stride  <= tile_C_stride;
                        r_msize   <= msize;
                        r_nsize   <= nsize;
                        r_row_cnt <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (can_store) begin
                        r_state <= (r_msize == '0) ? S_DONE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (res_valid) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (interface_ack) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_row_cnt <= r_row_cnt + SIZE_W'(1);
                            r_addr    <= w_next_addr;
                            r_state   <= S_WRITE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        store                   = 1'b0;
        busy                    = 1'b0;
        gen_addr_store          = 1'b0;
        next_row_addr_store     = '0;
        interface_en_store      = 1'b0;
        interface_rdwr_store    = 1'b0;
        interface_control_store = '0;
        res_buff_read           = 1'b0;
        done_store              = 1'b0;
        case (r_state)
            S_REQ: begin
                store = 1'b1;
                busy  = 1'b1;
                if (can_store) begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = r_addr;
                end
            end
            S_WRITE: begin
                busy                    = 1'b1;
                next_row_addr_store     = r_addr;
                interface_control_store = r_nsize;
                if (res_valid) begin
                    interface_en_store   = 1'b1;
                    interface_rdwr_store = 1'b1;
                    res_buff_read        = 1'b1;
                end
            end
            S_WAIT: begin
                busy                    = 1'b1;
                next_row_addr_store     = r_addr;
                interface_control_store = r_nsize;
                // The following row's address is presented in the ack cycle itself.
                if (interface_ack && !w_last) begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = w_next_addr;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done_store = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tile_store_controller.sv
// Directed scoreboard bench for tile_store_controller; checks row addresses,
// strobes, completion pulses and the ack watchdog (STORE_TIMEOUT_EN optional).
module tb_tile_store_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_store;
    logic [31:0] tile_C_addr;
    logic [31:0] tile_C_stride;
    logic [4:0]  msize;
    logic [4:0]  nsize;
    logic        can_store;
    logic        res_valid;
    logic        interface_ack;
    logic        store;
    logic        busy;
    logic        gen_addr_store;
    logic [31:0] next_row_addr_store;
    logic        interface_en_store;
    logic        interface_rdwr_store;
    logic [4:0]  interface_control_store;
    logic        res_buff_read;
    logic        done_store;
    logic        err_timeout;

    always #5 clk = ~clk;

    tile_store_controller #(
        .ADDR_W(32),
        .SIZE_W(5),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_store(start_store),
        .tile_C_addr(tile_C_addr),
        .tile_C_stride(tile_C_stride),
        .msize(msize),
        .nsize(nsize),
        .can_store(can_store),
        .res_valid(res_valid),
        .interface_ack(interface_ack),
        .store(store),
        .busy(busy),
        .gen_addr_store(gen_addr_store),
        .next_row_addr_store(next_row_addr_store),
        .interface_en_store(interface_en_store),
        .interface_rdwr_store(interface_rdwr_store),
        .interface_control_store(interface_control_store),
        .res_buff_read(res_buff_read),
        .done_store(done_store),
        .err_timeout(err_timeout)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_gen  = 0;
    int n_done = 0;

    logic [31:0] q_wr[$];
    logic [31:0] q_gen[$];
    logic [31:0] exp_n = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] s, input int m, input int n);
        exp_n = 32'(n);
        for (int r = 0; r < m; r++) q_wr.push_back(a + s * 32'(r));
        for (int r = 0; r < ((m == 0) ? 1 : m); r++) q_gen.push_back(a + s * 32'(r));
        tile_C_addr   = a;
        tile_C_stride = s;
        msize         = 5'(m);
        nsize         = 5'(n);
        start_store   = 1'b1;
        tick();
        start_store   = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (interface_en_store) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("request_seen", 32'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done_store) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", 32'(ok), 1);
        tick();
        chk("done_single_pulse", done_store, 0);
        chk("busy_clear_after_done", busy, 0);
    endtask

    // Serve `rows` requests; ack after ack_dly wait cycles; optionally hold
    // res_valid low for stall_len cycles before row stall_row.
    task automatic serve(input int rows, input int ack_dly, input int stall_row, input int stall_len);
        bit ok;
        for (int r = 0; r < rows; r++) begin
            wait_req(ok);
            if (!ok) return;
            tick();
            for (int i = 0; i < ack_dly; i++) begin
                chk("no_request_while_awaiting_ack", interface_en_store, 0);
                tick();
            end
            interface_ack = 1'b1;
            if (r + 1 == stall_row) res_valid = 1'b0;
            tick();
            interface_ack = 1'b0;
            if (r + 1 == stall_row) begin
                for (int i = 0; i < stall_len; i++) begin
                    if (i == 0) begin
                        start_store = 1'b1;
                        tile_C_addr = 32'hDEAD_0000;
                        msize       = 5'd1;
                    end
                    #1;
                    chk("no_request_without_res_valid", interface_en_store, 0);
                    chk("busy_during_stall", busy, 1);
                    tick();
                    start_store = 1'b0;
                end
                res_valid = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (interface_en_store) begin
                n_wr++;
                chk("write_rdwr", interface_rdwr_store, 1);
                chk("write_pops_buffer", res_buff_read, 1);
                chk("write_expected", 32'(q_wr.size() > 0), 1);
                if (q_wr.size() > 0) begin
                    chk("write_addr", next_row_addr_store, q_wr.pop_front());
                    chk("write_ctrl", 32'(interface_control_store), exp_n);
                end
            end
            if (res_buff_read) n_rd++;
            if (gen_addr_store) begin
                n_gen++;
                chk("gen_expected", 32'(q_gen.size() > 0), 1);
                if (q_gen.size() > 0) chk("gen_addr", next_row_addr_store, q_gen.pop_front());
            end
            if (done_store) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  w0, r0, d0, g0;
        bit  ok;

        rst           = 1'b1;
        start_store   = 1'b0;
        tile_C_addr   = '0;
        tile_C_stride = '0;
        msize         = '0;
        nsize         = '0;
        can_store     = 1'b0;
        res_valid     = 1'b0;
        interface_ack = 1'b0;
        repeat (3) tick();
        chk("rst_store", store, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen", gen_addr_store, 0);
        chk("rst_addr", next_row_addr_store, 0);
        chk("rst_en", interface_en_store, 0);
        chk("rst_rdwr", interface_rdwr_store, 0);
        chk("rst_ctrl", 32'(interface_control_store), 0);
        chk("rst_read", res_buff_read, 0);
        chk("rst_done", done_store, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        tick();

        // Basic four-row job
        can_store = 1'b1;
        res_valid = 1'b1;
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        start_job(32'h0000_1000, 32'h40, 4, 8);
        serve(4, 0, 0, 0);
        wait_done();
        chk("basic_writes", 32'(n_wr - w0), 4);
        chk("basic_reads", 32'(n_rd - r0), 4);
        chk("basic_done", 32'(n_done - d0), 1);
        chk("basic_queue_drained", 32'(q_wr.size()), 0);

        // Grant stall with stray ack outside WAIT_ACK
        can_store     = 1'b0;
        interface_ack = 1'b1;
        w0 = n_wr; d0 = n_done;
        start_job(32'h0000_5000, 32'h100, 2, 4);
        for (int i = 0; i < 10; i++) begin
            chk("stall_store", store, 1);
            chk("stall_no_gen", gen_addr_store, 0);
            chk("stall_no_write", interface_en_store, 0);
            tick();
        end
        interface_ack = 1'b0;
        can_store     = 1'b1;
        #1;
        chk("grant_gen", gen_addr_store, 1);
        serve(2, 0, 0, 0);
        wait_done();
        chk("stall_writes", 32'(n_wr - w0), 2);
        chk("stall_done", 32'(n_done - d0), 1);

        // Back-pressure, grant dropped after use, start while busy
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        start_job(32'h0000_8000, 32'h20, 4, 6);
        tick();
        can_store = 1'b0;
        serve(4, 3, 2, 5);
        can_store = 1'b1;
        wait_done();
        chk("bp_writes", 32'(n_wr - w0), 4);
        chk("bp_reads", 32'(n_rd - r0), 4);
        chk("bp_done", 32'(n_done - d0), 1);
        chk("bp_queue_drained", 32'(q_wr.size()), 0);

        // msize == 0
        w0 = n_wr; d0 = n_done; g0 = n_gen;
        start_job(32'h0000_9000, 32'h40, 0, 8);
        chk("m0_store", store, 1);
        tick();
        chk("m0_done_after_grant", done_store, 1);
        tick();
        chk("m0_done_pulse_ends", done_store, 0);
        chk("m0_busy_clear", busy, 0);
        chk("m0_no_writes", 32'(n_wr - w0), 0);
        chk("m0_done_count", 32'(n_done - d0), 1);
        chk("m0_gen_count", 32'(n_gen - g0), 1);

        // Address wrap, start pulse in the DONE cycle is ignored
        w0 = n_wr; d0 = n_done;
        start_job(32'hFFFF_FFC0, 32'h40, 2, 5);
        serve(2, 0, 0, 0);
        #1;
        chk("wrap_done", done_store, 1);
        start_store = 1'b1;
        tile_C_addr = 32'h0000_1234;
        msize       = 5'd3;
        tick();
        start_store = 1'b0;
        chk("done_start_ignored_busy", busy, 0);
        chk("done_start_ignored_store", store, 0);
        tick();
        chk("done_start_still_idle", busy, 0);
        chk("wrap_writes", 32'(n_wr - w0), 2);
        chk("wrap_done_count", 32'(n_done - d0), 1);

        // Largest job
        w0 = n_wr; r0 = n_rd; d0 = n_done;
        start_job(32'h0000_2000, 32'h4, 31, 31);
        serve(31, 0, 0, 0);
        wait_done();
        chk("max_writes", 32'(n_wr - w0), 31);
        chk("max_reads", 32'(n_rd - r0), 31);
        chk("max_done", 32'(n_done - d0), 1);

        // Reset during WAIT_ACK of row 1, then a clean job
        d0 = n_done;
        start_job(32'h0000_3000, 32'h10, 4, 2);
        serve(1, 0, 0, 0);
        wait_req(ok);
        tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst_store", store, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_en", interface_en_store, 0);
        chk("midrst_gen", gen_addr_store, 0);
        chk("midrst_read", res_buff_read, 0);
        chk("midrst_done", done_store, 0);
        chk("midrst_addr", next_row_addr_store, 0);
        chk("midrst_ctrl", 32'(interface_control_store), 0);
        rst = 1'b0;
        q_wr.delete();
        q_gen.delete();
        tick();
        chk("midrst_no_done", 32'(n_done - d0), 0);
        w0 = n_wr;
        start_job(32'h0000_3000, 32'h10, 3, 2);
        serve(3, 0, 0, 0);
        wait_done();
        chk("postrst_writes", 32'(n_wr - w0), 3);
        chk("postrst_done", 32'(n_done - d0), 1);

        // Ack withheld
        d0 = n_done;
        start_job(32'h0000_4000, 32'h8, 1, 3);
        wait_req(ok);
        tick();
`ifdef STORE_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_err_not_yet", err_timeout, 0);
            chk("to_still_busy", busy, 1);
        end
        tick();
        chk("to_done_pulse", done_store, 1);
        chk("to_err_set", err_timeout, 1);
        tick();
        chk("to_busy_clear", busy, 0);
        repeat (5) tick();
        chk("to_err_sticky", err_timeout, 1);
        chk("to_done_count", 32'(n_done - d0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_err_cleared_by_rst", err_timeout, 0);
`else
        repeat (80) tick();
        chk("noto_err", err_timeout, 0);
        chk("noto_busy", busy, 1);
        chk("noto_no_request", interface_en_store, 0);
        chk("noto_no_done", 32'(n_done - d0), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("noto_busy_after_rst", busy, 0);
        chk("noto_err_after_rst", err_timeout, 0);
`endif
        q_wr.delete();
        q_gen.delete();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
